alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one 36-bit scalar ALU (ops 0-8, registered result, nz/ez/lz/gz/le/ge compare flags)
//  among NUM_REQ requesters. Round-robin grant, valid/ready handshakes on both sides, in-order
//  result buffer with credit-based issue. Results are routed back to the issuing requester.
// PARAMETERS
//  NUM_REQ    2   number of requesters (2..8)
//  WIDTH      36  operand/result width
//  ALU_LAT    1   cycles from ALU input to valid alu_out (>=1)
//  RES_DEPTH  3   result FIFO entries = issue credits; full throughput requires >= ALU_LAT+2
// PORTS
//  clk        in   1              clock, all state on posedge
//  rst_n      in   1              synchronous active-low reset
//  req_valid  in   NUM_REQ        request i presents op/operands
//  req_ready  out  NUM_REQ        one-hot grant; accept when valid&ready
//  req_op     in   4*NUM_REQ      op of requester i at [4i+3:4i]
//  req_a      in   WIDTH*NUM_REQ  operand A of requester i
//  req_b      in   WIDTH*NUM_REQ  operand B of requester i
//  alu_op     out  4              to ALU op
//  alu_a      out  WIDTH          to ALU A
//  alu_b      out  WIDTH          to ALU B
//  alu_out    in   WIDTH          ALU result, valid ALU_LAT cycles after issue
//  alu_flags  in   6              {nz,ez,lz,gz,le,ge} from ALU, aligned with alu_out
//  rsp_valid  out  NUM_REQ        one-hot: FIFO head belongs to requester i
//  rsp_ready  in   NUM_REQ        requester i consumes head
//  rsp_data   out  WIDTH          head result
//  rsp_flags  out  6              head flags; forced 0 unless head op == 4'b1000
//  rsp_err    out  1              head op was illegal (9-15)
//  busy       out  1              credit count != 0
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): FIFO emptied, in-flight tags cleared, credit count=0,
//    RR pointer=0; all outputs 0 next cycle. Operations in flight at reset are dropped, never returned.
//  - Issue allowed in cycle c iff count<RES_DEPTH. Then req_ready = one-hot of first req_valid
//    at or after RR pointer (wrapping); else req_ready=0. req_ready is combinational; requesters
//    must hold op/operands stable while valid&&!ready.
//  - On handshake of i: pointer <= (i+1)%NUM_REQ; tag {valid,id,err,is_cmp} enters ALU_LAT-stage
//    shift register. No handshake: pointer holds.
//  - alu_op/alu_a/alu_b: combinational mux of granted requester; all-zero when no grant.
//    Illegal op (9-15): alu_op driven 0, tag err=1, stored result forced 0, flags 0.
//  - Tag exiting shift register with valid=1: {alu_out, alu_flags, id, err} written to FIFO at that
//    posedge; rsp_* reflect FIFO head from the next cycle (handshake cycle c -> rsp_valid in c+ALU_LAT+1).
//  - Pop when rsp_valid[head.id]&&rsp_ready[head.id]; rsp_ready of other requesters ignored.
//  - count: +1 per issue, -1 per pop, both same cycle -> unchanged; registered, so a pop frees a
//    credit from the next cycle. Count never exceeds RES_DEPTH, so FIFO cannot overflow.
//  - Results return in global issue order; a stalled head blocks all requesters (no reordering).
//  - Flags for op 8 pass through untouched; width arithmetic is the ALU's, no masking here.
// TESTING
//  1 Single: req0 op=0 A=5 B=3 -> ready0 same cycle; rsp_valid=01, rsp_data=8, flags=0 at c+2.
//  2 Contention: both valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1..., one issue/cycle,
//    responses alternate ids in issue order.
//  3 Backpressure: rsp_ready=0, req0 streaming -> exactly 3 issues then req_ready=0; raise rsp_ready
//    -> one pop per cycle, issue resumes the cycle after the first pop.
//  4 Compare: op=8 A=3 B=5 -> rsp_data=36'hFFFFFFFFE, flags nz=1 lz=1 le=1, ez=gz=ge=0.
//  5 Illegal: op=12 A=7 B=9 -> alu_op=0, rsp_err=1, rsp_data=0, flags=0.
//  6 Reset mid-op: 2 in flight, rst_n=0 one cycle -> no rsp_valid afterwards, busy=0, next grant to req0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one external pipelined ALU among NUM_REQ requesters.
// Results return in issue order through a credit-limited FIFO and are routed back by requester id.
module alu_share_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int WIDTH     = 36,
   parameter int ALU_LAT   = 1,
   parameter int RES_DEPTH = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   output logic [NUM_REQ-1:0]       o_req_ready,
   input  logic [4*NUM_REQ-1:0]     i_req_op,
   input  logic [WIDTH*NUM_REQ-1:0] i_req_a,
   input  logic [WIDTH*NUM_REQ-1:0] i_req_b,
   output logic [3:0]               o_alu_op,
   output logic [WIDTH-1:0]         o_alu_a,
   output logic [WIDTH-1:0]         o_alu_b,
   input  logic [WIDTH-1:0]         i_alu_out,
   input  logic [5:0]               i_alu_flags,
   output logic [NUM_REQ-1:0]       o_rsp_valid,
   input  logic [NUM_REQ-1:0]       i_rsp_ready,
   output logic [WIDTH-1:0]         o_rsp_data,
   output logic [5:0]               o_rsp_flags,
   output logic                     o_rsp_err,
   output logic                     o_busy
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int AW  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int CW  = $clog2(RES_DEPTH + 1);
   localparam logic [CW-1:0]  DEPTH_C  = CW'(RES_DEPTH);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic [AW-1:0]  PTR_LAST = AW'(RES_DEPTH - 1);
   localparam logic [IDW-1:0] ID_ONE   = IDW'(1);
   localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_REQ - 1);

   logic [IDW-1:0]     r_rr_ptr;
   logic [CW-1:0]      r_count;
   logic [ALU_LAT-1:0] r_tag_valid;
   logic [ALU_LAT-1:0] r_tag_err;
   logic [ALU_LAT-1:0] r_tag_cmp;
   logic [IDW-1:0]     r_tag_id [ALU_LAT];

   logic [WIDTH-1:0]   r_fifo_data  [RES_DEPTH];
   logic [5:0]         r_fifo_flags [RES_DEPTH];
   logic [IDW-1:0]     r_fifo_id    [RES_DEPTH];
   logic               r_fifo_err   [RES_DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_fifo_cnt;

   int                 w_idx;
   logic               w_grant_any;
   logic [IDW-1:0]     w_gid;
   logic               w_issue;
   logic [3:0]         w_gop;
   logic               w_gerr;
   logic               w_gcmp;
   logic               w_push;
   logic               w_pop;
   logic               w_nonempty;
   logic [IDW-1:0]     w_head_id;

   // Scan downward so the lowest offset from the pointer is the last (winning) assignment.
   always_comb begin
      w_grant_any = 1'b0;
      w_gid       = '0;
      w_idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         if (i_req_valid[w_idx]) begin
            w_grant_any = 1'b1;
            w_gid       = IDW'(w_idx);
         end
      end
   end

   assign w_issue = rst_n && (r_count < DEPTH_C) && w_grant_any;
   assign w_gop   = i_req_op[int'(w_gid)*4 +: 4];
   assign w_gerr  = (w_gop > 4'd8);
   assign w_gcmp  = (w_gop == 4'd8);

   always_comb begin
      o_req_ready = '0;
      if (w_issue) o_req_ready[w_gid] = 1'b1;
   end

   assign o_alu_op = (w_issue && !w_gerr) ? w_gop : 4'd0;
   assign o_alu_a  = w_issue ? i_req_a[int'(w_gid)*WIDTH +: WIDTH] : '0;
   assign o_alu_b  = w_issue ? i_req_b[int'(w_gid)*WIDTH +: WIDTH] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_issue) r_rr_ptr <= (w_gid == ID_LAST) ? '0 : w_gid + ID_ONE;
         case ({w_issue, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Tag pipeline tracks each issued op so its result is captured exactly when the ALU presents it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tag_valid <= '0;
      end else begin
         r_tag_valid[0] <= w_issue;
         for (int s = 1; s < ALU_LAT; s++) r_tag_valid[s] <= r_tag_valid[s-1];
      end
      r_tag_err[0] <= w_gerr;
      r_tag_cmp[0] <= w_gcmp;
      r_tag_id[0]  <= w_gid;
      for (int s = 1; s < ALU_LAT; s++) begin
         r_tag_err[s] <= r_tag_err[s-1];
         r_tag_cmp[s] <= r_tag_cmp[s-1];
         r_tag_id[s]  <= r_tag_id[s-1];
      end
   end

   assign w_push     = r_tag_valid[ALU_LAT-1];
   assign w_nonempty = (r_fifo_cnt != '0);
   assign w_head_id  = r_fifo_id[r_rd_ptr];
   assign w_pop      = w_nonempty && i_rsp_ready[w_head_id];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= r_tag_err[ALU_LAT-1] ? '0 : i_alu_out;
            r_fifo_flags[r_wr_ptr] <= r_tag_cmp[ALU_LAT-1] ? i_alu_flags : 6'd0;
            r_fifo_id[r_wr_ptr]    <= r_tag_id[ALU_LAT-1];
            r_fifo_err[r_wr_ptr]   <= r_tag_err[ALU_LAT-1];
            r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
         end
         if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_ONE;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_ONE;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
      assign o_rsp_valid[gi] = w_nonempty && (w_head_id == IDW'(gi));
   end

   assign o_rsp_data  = w_nonempty ? r_fifo_data[r_rd_ptr]  : '0;
   assign o_rsp_flags = w_nonempty ? r_fifo_flags[r_rd_ptr] : 6'd0;
   assign o_rsp_err   = w_nonempty && r_fifo_err[r_rd_ptr];
   assign o_busy      = (r_count != '0);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a registered ALU model and an in-order response scoreboard.
module tb_alu_share_arbiter;
   localparam int N = 2;
   localparam int W = 36;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [4*N-1:0] req_op = '0;
   logic [W*N-1:0] req_a = '0;
   logic [W*N-1:0] req_b = '0;
   logic [3:0]     alu_op;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [W-1:0]   alu_out = '0;
   logic [5:0]     alu_flags = '0;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready = '0;
   logic [W-1:0]   rsp_data;
   logic [5:0]     rsp_flags;
   logic           rsp_err;
   logic           busy;

   typedef struct {
      int           id;
      logic [W-1:0] data;
      logic [5:0]   flags;
      logic         err;
   } exp_t;

   exp_t         sb_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] last_data;
   logic [5:0]   last_flags;
   logic         last_err;
   int           exp_ptr;

   alu_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ALU_LAT(1), .RES_DEPTH(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
      .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
      .i_alu_out(alu_out), .i_alu_flags(alu_flags),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(rsp_data), .o_rsp_flags(rsp_flags), .o_rsp_err(rsp_err),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << 1;
         4'd6: return a >> 1;
         4'd7: return ~a;
         4'd8: return a - b;
         default: return a + b;
      endcase
   endfunction

   function automatic logic [5:0] cmp_fn(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      sa = a;
      sb = b;
      return {a != b, a == b, sa < sb, sa > sb, sa <= sb, sa >= sb};
   endfunction

   // ALU model: one registered stage, flags always computed so the DUT has to mask them.
   always @(posedge clk) begin
      alu_out   <= alu_fn(alu_op, alu_a, alu_b);
      alu_flags <= cmp_fn(alu_a, alu_b);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i]      = v;
      req_op[4*i +: 4]  = op;
      req_a[W*i +: W]   = a;
      req_b[W*i +: W]   = b;
   endtask

   task automatic rand_req(input int i);
      logic [63:0] ta;
      logic [63:0] tb;
      ta = {$urandom, $urandom};
      tb = {$urandom, $urandom};
      set_req(i, 1'b1, 4'($urandom_range(0, 8)), ta[W-1:0], tb[W-1:0]);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      tick();
      chk("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   // Scoreboard monitor samples one time unit before each rising edge.
   always @(negedge clk) begin
      exp_t e;
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      #4;
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               op = req_op[4*i +: 4];
               a  = req_a[W*i +: W];
               b  = req_b[W*i +: W];
               e.id    = i;
               e.err   = (op > 4'd8);
               e.data  = e.err ? '0 : alu_fn(op, a, b);
               e.flags = (op == 4'd8) ? cmp_fn(a, b) : 6'd0;
               sb_q.push_back(e);
            end
         end
         if ((rsp_valid & rsp_ready) != '0) begin
            if (sb_q.size() == 0) begin
               chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("rsp_id", 64'(rsp_valid), 64'(1 << e.id));
               chk("rsp_data", 64'(rsp_data), 64'(e.data));
               chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
               chk("rsp_err", 64'(rsp_err), 64'(e.err));
               $display("rsp id=%0d data=%h flags=%b err=%0d", e.id, rsp_data, rsp_flags, rsp_err);
               last_data  = rsp_data;
               last_flags = rsp_flags;
               last_err   = rsp_err;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick(); #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_alu_op", 64'({alu_op, alu_a}), 64'd0);

      // Single op from req0, latency c+2
      rsp_ready = 2'b11;
      set_req(0, 1'b1, 4'd0, 36'd5, 36'd3);
      #1;
      chk("t1_ready", 64'(req_ready), 64'd1);
      chk("t1_alu_a", 64'(alu_a), 64'd5);
      tick();
      set_req(0, 1'b0, 4'd0, 36'd0, 36'd0);
      #1;
      chk("t1_rsp_early", 64'(rsp_valid), 64'd0);
      chk("t1_busy", 64'(busy), 64'd1);
      tick(); #1;
      chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t1_rsp_data", 64'(rsp_data), 64'd8);
      chk("t1_rsp_flags", 64'(rsp_flags), 64'd0);
      tick(); #1;
      chk("t1_busy_clear", 64'(busy), 64'd0);
      exp_ptr = 1;

      // Contention: both requesters continuously valid, grants alternate
      rand_req(0);
      rand_req(1);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("t2_grant", 64'(req_ready), 64'(1 << exp_ptr));
         $display("t2 cycle=%0d ready=%b op=%0d", k, req_ready, alu_op);
         tick();
         rand_req(exp_ptr);
         exp_ptr = 1 - exp_ptr;
      end
      req_valid = '0;
      drain();

      // Backpressure: credits run out after three issues; other requester's ready is ignored
      rsp_ready = 2'b10;
      rand_req(0);
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("t3_ready", 64'(req_ready), (k < 3) ? 64'd1 : 64'd0);
         tick();
         if (k < 3) rand_req(0);
      end
      #1;
      chk("t3_head_held", 64'(rsp_valid), 64'd1);
      chk("t3_busy", 64'(busy), 64'd1);
      tick();
      rsp_ready = 2'b11;
      #1;
      chk("t3_ready_pop_cycle", 64'(req_ready), 64'd0);
      tick(); #1;
      chk("t3_ready_resume", 64'(req_ready), 64'd1);
      tick();
      req_valid = '0;
      drain();
      exp_ptr = 1;

      // Compare op via req1
      set_req(1, 1'b1, 4'd8, 36'd3, 36'd5);
      #1;
      chk("t4_ready", 64'(req_ready), 64'd2);
      chk("t4_alu_op", 64'(alu_op), 64'd8);
      tick();
      req_valid = '0;
      drain();
      chk("t4_data", 64'(last_data), 64'h0_FFFF_FFFE | 64'hF_0000_0000);
      chk("t4_flags", 64'(last_flags), 64'b101010);

      // Illegal op via req0
      set_req(0, 1'b1, 4'd12, 36'd7, 36'd9);
      #1;
      chk("t5_ready", 64'(req_ready), 64'd1);
      chk("t5_alu_op", 64'(alu_op), 64'd0);
      tick();
      req_valid = '0;
      drain();
      chk("t5_err", 64'(last_err), 64'd1);
      chk("t5_data", 64'(last_data), 64'd0);
      chk("t5_flags", 64'(last_flags), 64'd0);

      // Reset with two ops in flight; pointer would otherwise favour req1
      rsp_ready = 2'b00;
      rand_req(1);
      #1;
      chk("t6_grant1", 64'(req_ready), 64'd2);
      tick();
      req_valid = '0;
      rand_req(0);
      #1;
      chk("t6_grant0", 64'(req_ready), 64'd1);
      tick();
      req_valid = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb_q.delete();
      rsp_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
         chk("t6_busy", 64'(busy), 64'd0);
         tick();
      end
      rand_req(0);
      rand_req(1);
      #1;
      chk("t6_grant_after_rst", 64'(req_ready), 64'd1);
      tick();
      req_valid = '0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
